// File: rtl/neuron_feeder.sv
// Sequencer in front of neuron_ip: packs NUM_INPUTS (input, weight) beats into the
// neuron's parallel buses, pulses start, and returns the neuron's result with a timeout.
module neuron_feeder #(
    parameter int DATA_W     = 8,
    parameter int NUM_INPUTS = 8,
    parameter int TIMEOUT    = 63
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [DATA_W-1:0]            w_data,
    output logic [DATA_W*NUM_INPUTS-1:0] nrn_inputs,
    output logic [DATA_W*NUM_INPUTS-1:0] nrn_weights,
    output logic                         start_signal,
    input  logic                         ready_signal,
    input  logic [DATA_W-1:0]            nrn_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DATA_W-1:0]            res_data,
    output logic                         res_err,
    output logic                         busy
);

    localparam int BUS_W  = DATA_W * NUM_INPUTS;
    localparam int CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_INPUTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                rdy_q;
    logic                rdy_rise;

    // Both streams transfer on a rising edge where valid && ready; valid holds its
    // payload until then, and in_ready / res_valid depend on registered state only.
    assign rdy_rise = ready_signal && !rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            wait_cnt     <= '0;
            rdy_q        <= 1'b0;
            nrn_inputs   <= '0;
            nrn_weights  <= '0;
            res_data     <= '0;
            res_err      <= 1'b0;
            in_ready     <= 1'b0;
            start_signal <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Tracked in every state so a level already high at START is not an edge.
            rdy_q <= ready_signal;
            case (state)
                S_IDLE: begin
                    state    <= S_LOAD;
                    in_ready <= 1'b1;
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        // First beat ends up in the most significant element.
                        nrn_inputs  <= {nrn_inputs[BUS_W-DATA_W-1:0], in_data};
                        nrn_weights <= {nrn_weights[BUS_W-DATA_W-1:0], w_data};
                        if (cnt == LAST_BEAT) begin
                            cnt          <= '0;
                            state        <= S_START;
                            in_ready     <= 1'b0;
                            start_signal <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    start_signal <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (rdy_rise) begin
                        res_data  <= nrn_out;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt  <= wait_cnt + WAIT_W'(1);
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    in_ready     <= 1'b0;
                    start_signal <= 1'b0;
                    res_valid    <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: table of scripted evaluations, randomized evaluations against
// a positional packing / latency model, and reset-in-flight sequences.
module tb_neuron_feeder;

    localparam int DW = 8;
    localparam int NI = 8;
    localparam int TO = 63;
    localparam int BW = DW * NI;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] w_data;
    logic [BW-1:0] nrn_inputs;
    logic [BW-1:0] nrn_weights;
    logic          start_signal;
    logic          ready_signal;
    logic [DW-1:0] nrn_out;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    neuron_feeder #(.DATA_W(DW), .NUM_INPUTS(NI), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_data(w_data), .nrn_inputs(nrn_inputs),
        .nrn_weights(nrn_weights), .start_signal(start_signal),
        .ready_signal(ready_signal), .nrn_out(nrn_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [0:NI-1][DW-1:0] ins;
        logic [0:NI-1][DW-1:0] ws;
        int                    delay;   // 0 = held high from before start; else edge of first high sample
        logic [DW-1:0]         nout;
        int                    hold;
        logic [BW-1:0]         exp_in;
        logic [BW-1:0]         exp_w;
        logic [DW-1:0]         exp_data;
        logic                  exp_err;
        int                    exp_lat;
    } vec_t;

    vec_t tbl[5];

    function automatic vec_t mk(logic [BW-1:0] ins, logic [BW-1:0] ws, int d,
                                logic [DW-1:0] nout, int hold, logic [BW-1:0] ei,
                                logic [BW-1:0] ew, logic [DW-1:0] ed, logic ee, int el);
        vec_t v;
        v.ins = ins; v.ws = ws; v.delay = d; v.nout = nout; v.hold = hold;
        v.exp_in = ei; v.exp_w = ew; v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // reference model: beat i occupies element NI-1-i of the bus
    function automatic logic [BW-1:0] place(logic [0:NI-1][DW-1:0] b);
        logic [BW-1:0] bus;
        bus = '0;
        for (int i = 0; i < NI; i++) bus[(NI-1-i)*DW +: DW] = b[i];
        return bus;
    endfunction

    function automatic vec_t model(logic [0:NI-1][DW-1:0] ins, logic [0:NI-1][DW-1:0] ws,
                                   int d, logic [DW-1:0] nout, int hold);
        vec_t v;
        bit captured;
        captured = (d >= 2) && (d <= TO + 1);
        v = mk(ins, ws, d, nout, hold, place(ins), place(ws),
               captured ? nout : 8'h00, !captured, captured ? d : TO + 1);
        return v;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_ctl"}, 64'({in_ready, start_signal, res_valid, res_err, busy}), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
        check({tag, "_buses"}, 64'(nrn_inputs | nrn_weights), 64'd0);
    endtask

    task automatic do_reset(string tag);
        in_valid = 1'b0;
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check({tag, "_idle_cycle"}, 64'(in_ready), 64'd0);
        tick();
        check({tag, "_load_cycle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic load_beats(input vec_t v, input bit bubbles, input int n,
                              output int got, output bit early);
        bit acc;
        got = 0;
        early = 1'b0;
        for (int c = 0; c < 400 && got < n; c++) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = v.ins[got];
            w_data = v.ws[got];
            acc = in_valid && in_ready;
            tick();
            if (acc) got++;
            if (start_signal && got < NI) early = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_eval(input vec_t v, input bit bubbles, input string tag);
        int got;
        bit early;
        int lat;
        int viol;
        int unstable;
        logic [DW-1:0] exp_d;
        ready_signal = (v.delay == 0);
        nrn_out = v.nout;
        exp_q.push_back(v.exp_data);
        load_beats(v, bubbles, NI, got, early);
        check({tag, "_beats"}, 64'(got), 64'(NI));
        check({tag, "_early_start"}, 64'(early), 64'd0);
        check({tag, "_start"}, 64'({start_signal, busy, in_ready}), 64'b110);
        check({tag, "_inputs"}, nrn_inputs, v.exp_in);
        check({tag, "_weights"}, nrn_weights, v.exp_w);
        lat = 0;
        viol = 0;
        for (int k = 1; k <= TO + 10; k++) begin
            if (v.delay >= 2) ready_signal = (k >= v.delay);
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            w_data = 8'($urandom);
            tick();
            if (k == 1) check({tag, "_start_one_cycle"}, 64'(start_signal), 64'd0);
            if (in_ready) viol++;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_res_data"}, 64'(res_data), 64'(exp_d));
        check({tag, "_res_err"}, 64'(res_err), 64'(v.exp_err));
        check({tag, "_busy_result"}, 64'(busy), 64'd1);
        check({tag, "_buses_held"}, nrn_inputs ^ nrn_weights, v.exp_in ^ v.exp_w);
        unstable = 0;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (!res_valid || res_data !== exp_d || res_err !== v.exp_err || in_ready) unstable++;
        end
        check({tag, "_result_held"}, 64'(unstable), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ready_signal = 1'b0;
        check({tag, "_after_hs"}, 64'({in_ready, res_valid, busy}), 64'b100);
        check({tag, "_no_ready_busy"}, 64'(viol), 64'd0);
    endtask

    initial begin
        int got;
        bit early;
        logic [0:NI-1][DW-1:0] ri;
        logic [0:NI-1][DW-1:0] rw;
        int d;
        int sel;

        rst_n = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        w_data = '0;
        ready_signal = 1'b0;
        nrn_out = '0;
        res_ready = 1'b0;

        tbl[0] = mk(64'h068D85AD0DB181A9, 64'h34151098870D0205, 5, 8'h9B, 3,
                    64'h068D85AD0DB181A9, 64'h34151098870D0205, 8'h9B, 1'b0, 5);
        tbl[1] = mk(64'h068D85AD0DB181A9, 64'h34151098870D0205, 0, 8'h77, 1,
                    64'h068D85AD0DB181A9, 64'h34151098870D0205, 8'h00, 1'b1, TO + 1);
        tbl[2] = mk(64'h068D85AD0DB181A9, 64'h34151098870D0205, TO + 1, 8'h42, 0,
                    64'h068D85AD0DB181A9, 64'h34151098870D0205, 8'h42, 1'b0, TO + 1);
        tbl[3] = mk(64'h0102030405060708, 64'hF1F2F3F4F5F6F7F8, 2, 8'h80, 2,
                    64'h0102030405060708, 64'hF1F2F3F4F5F6F7F8, 8'h80, 1'b0, 2);
        tbl[4] = mk(64'hFF00FF00807F0180, 64'h0011223344556677, TO + 2, 8'h5A, 0,
                    64'hFF00FF00807F0180, 64'h0011223344556677, 8'h00, 1'b1, TO + 1);

        #2;
        do_reset("por");

        for (int i = 0; i < 5; i++) run_eval(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NI; i++) begin
                ri[i] = 8'($urandom);
                rw[i] = 8'($urandom);
            end
            sel = $urandom_range(0, 3);
            case (sel)
                0: d = 0;
                1: d = $urandom_range(2, 12);
                2: d = $urandom_range(TO - 3, TO + 3);
                default: d = $urandom_range(2, 40);
            endcase
            run_eval(model(ri, rw, d, 8'($urandom), $urandom_range(0, 3)), 1'b1,
                     $sformatf("rnd%0d", n));
        end

        load_beats(tbl[3], 1'b0, 4, got, early);
        check("partial_beats", 64'(got), 64'd4);
        do_reset("rst_load");
        run_eval(tbl[0], 1'b0, "after_rst_load");

        ready_signal = 1'b0;
        load_beats(tbl[3], 1'b0, NI, got, early);
        check("wait_beats", 64'(got), 64'(NI));
        tick();
        tick();
        tick();
        check("wait_busy", 64'({busy, res_valid}), 64'b10);
        do_reset("rst_wait");
        run_eval(tbl[0], 1'b1, "after_rst_wait");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_feeder.md
# neuron_feeder

Sequencer that sits directly upstream of the `neuron_ip` datapath and downstream of it for result return. It accepts NUM_INPUTS (input, weight) byte pairs over a valid/ready stream and packs them into the neuron's parallel buses. It then pulses `start_signal`, waits for the neuron's `ready_signal`, and returns the neuron's 8-bit output over a second valid/ready stream, with a timeout guard. All values are 8-bit sign-magnitude (bit 7 = sign) and pass through the block unmodified.

## Interface
- `DATA_W`, 8, element width in bits (sign-magnitude)
- `NUM_INPUTS`, 8, elements per neuron evaluation; bus width = DATA_W*NUM_INPUTS
- `TIMEOUT`, 63, max WAIT cycles before error completion (≥2)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  block can accept a beat
- `in_data`  in  DATA_W  input element of this beat
- `w_data`  in  DATA_W  weight element of this beat
- `nrn_inputs`  out  DATA_W*NUM_INPUTS  to neuron `inputs`
- `nrn_weights`  out  DATA_W*NUM_INPUTS  to neuron `weights`
- `start_signal`  out  1  one-cycle start pulse to neuron
- `ready_signal`  in  1  neuron done (level, from neuron)
- `nrn_out`  in  DATA_W  neuron result
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accepts result
- `res_data`  out  DATA_W  captured result (0 on timeout)
- `res_err`  out  1  qualifies `res_data`: 1 = timeout
- `busy`  out  1  high in START, WAIT, RESULT

## Operation
- States: IDLE, LOAD, START, WAIT, RESULT.
- IDLE: entered on reset. Goes to LOAD unconditionally on the next edge.
- LOAD: `in_ready`=1. Each `in_valid&&in_ready` edge shifts the beat into the packing registers and increments `cnt`.
  - First beat lands in bits [W-1:W-8] (MSB byte); the last beat lands in [7:0].
  - `in_data` is packed into `nrn_inputs`; `w_data` is packed into `nrn_weights`.
  - On the beat where `cnt`==NUM_INPUTS-1: `cnt`←0, go to START.
- START: `start_signal`=1 for exactly this one cycle. Clear the wait counter. Go to WAIT.
- WAIT: `rdy_q` registers `ready_signal` every cycle.
  - Completion is the rising edge `ready_signal && !rdy_q`. A level already high at START entry is ignored until it falls and rises again.
  - On edge: `res_data`←`nrn_out`, `res_err`←0, go to RESULT.
  - Otherwise the wait counter increments. When it reaches TIMEOUT: `res_data`←0, `res_err`←1, go to RESULT.
  - If an edge and the timeout occur on the same edge, the edge wins (valid result, `res_err`=0).
- RESULT: `res_valid`=1, with `res_data`/`res_err` stable. On `res_valid&&res_ready` go to LOAD.
- `nrn_inputs`/`nrn_weights` hold their values from the last LOAD beat until the first beat of the next LOAD. They are never cleared except by reset.
- No overlap: beats are never accepted outside LOAD.

## Timing
- Reset (async, immediate on `rst_n`=0):
  - state=IDLE, `cnt`=0, wait counter=0, `rdy_q`=0.
  - Outputs: `in_ready`=0, `start_signal`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `busy`=0, buses=0.
  - Reset mid-operation discards partial beats and any pending result, and drops `start_signal` the same instant.
- First cycle after `rst_n` release: IDLE (`in_ready`=0). Second cycle: LOAD (`in_ready`=1).
- Last beat accepted at edge E: START during cycle E→E+1, so `start_signal` is high from E to E+1.
- Buses are valid and stable from E until the next LOAD beat. The neuron sees them in the same cycle as `start_signal`.
- Rising `ready_signal` sampled at edge R: `res_valid`=1 from edge R onward (registered). `busy` stays high.
- Minimum loop, neuron responding one cycle after start: 8 beats + START + 1 WAIT + 1 RESULT = 11 cycles.
- Timeout: if no edge arrives, `res_valid` rises TIMEOUT+1 edges after START entry.
- Result handshake at edge H: LOAD from H, so `in_ready`=1 and `res_valid`=0 in the following cycle.
- `in_ready`, `res_valid`, `start_signal` and `busy` are decoded from registered state only. There is no combinational input-to-output path.

## Test plan
- Pack order:
  - Stimulus: beats w = 0x34, 0x15, 0x10, 0x98, 0x87, 0x0D, 0x02, 0x05 with in = 0x06, 0x8D, 0x85, 0xAD, 0x0D, 0xB1, 0x81, 0xA9.
  - Required: `nrn_weights`=64'h34151098870D0205 and `nrn_inputs`=64'h068D85AD0DB181A9 when `start_signal`=1.
  - Required: `start_signal` high exactly 1 cycle, immediately after the 8th beat.
- Backpressure and bubbles:
  - Stimulus: `in_valid` toggled randomly.
  - Required: exactly 8 accepted beats per evaluation; `in_ready`=0 in START/WAIT/RESULT.
- Result capture:
  - Stimulus: neuron model raises `ready_signal` 5 cycles after start with `nrn_out`=0x9B; hold `res_ready`=0 for 3 cycles.
  - Required: `res_valid` stays high with `res_data`=0x9B and `res_err`=0 until the handshake; `in_ready`=1 in the next cycle.
- Stale ready and timeout:
  - Stimulus: `ready_signal` held high before START and never toggled.
  - Required: no capture; `res_valid` with `res_err`=1 and `res_data`=0x00 at TIMEOUT+1 edges after START.
- Edge/timeout tie:
  - Stimulus: `ready_signal` rises on the exact timeout edge with `nrn_out`=0x42.
  - Required: `res_data`=0x42, `res_err`=0.
- Reset mid-operation:
  - Stimulus: `rst_n` pulled low after 4 beats, and again during WAIT.
  - Required: all outputs 0 immediately; after release, one IDLE cycle, then LOAD with `cnt`=0. A full 8-beat load reproduces the first scenario's buses.
